// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Byte-stream program loader for the PseudoCPU control unit. It takes a
//   valid/ready byte stream from the host link and uses it to fill the
//   instruction memory and load operands a and b. It then enables the core.
//
//   Stream (multi-byte fields LSB first):
//      N | N words of IW/8 bytes | DW/8 bytes of a | DW/8 bytes of b | [chk]
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//      When defined, one trailing checksum byte is expected. The load passes
//      when the XOR of every stream byte, including the checksum, is zero.
//      A failed check parks the loader in ERR with err=1.
//
//   Ports:
//      clk        rising-edge clock
//      rst        synchronous active-high reset
//      in_valid   host byte valid
//      in_data    host byte
//      in_ready   loader accepts a byte this cycle
//      restart    one-cycle pulse; RUN/ERR -> IDLE
//      imem_we    one-cycle instruction write strobe
//      imem_addr  instruction write address (word index)
//      imem_wdata instruction write data
//      a, b       operands presented to the core
//      cpu_run    core enable
//      busy       high while a load is in progress
//      err        checksum failure flag (always 0 without the macro)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int IW = 16,
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic          restart,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [IW-1:0] imem_wdata,
   output logic [DW-1:0] a,
   output logic [DW-1:0] b,
   output logic          cpu_run,
   output logic          busy,
   output logic          err
);

   localparam logic [3:0] IW_LAST = 4'(IW / 8 - 1);
   localparam logic [3:0] DW_LAST = 4'(DW / 8 - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INSTR = 3'd1,
      S_OPA   = 3'd2,
      S_OPB   = 3'd3,
      S_RUN   = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      S_CHK   = 3'd5,
      S_ERR   = 3'd6
`endif
   } state_t;

   // Shift a byte into the top of a word. Because bytes arrive LSB first,
   // the first byte ends up in bits [7:0] after IW/8 shifts.
   function automatic logic [IW-1:0] shift_word(input logic [IW-1:0] cur,
                                                input logic [7:0]    byt);
      logic [IW-1:0] t;
      t = cur >> 8;
      t[IW-1 -: 8] = byt;
      return t;
   endfunction

   // Same LSB-first shift, applied at operand width.
   function automatic logic [DW-1:0] shift_opnd(input logic [DW-1:0] cur,
                                                input logic [7:0]    byt);
      logic [DW-1:0] t;
      t = cur >> 8;
      t[DW-1 -: 8] = byt;
      return t;
   endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running XOR checksum over the stream.
   function automatic logic [7:0] xor_fold(input logic [7:0] acc,
                                           input logic [7:0] byt);
      return acc ^ byt;
   endfunction
`endif

   state_t        state_q,      state_d;
   logic [7:0]    n_q,          n_d;
   logic [AW-1:0] word_idx_q,   word_idx_d;
   logic [3:0]    byte_cnt_q,   byte_cnt_d;
   logic [IW-1:0] word_sr_q,    word_sr_d;
   logic [DW-1:0] a_sh_q,       a_sh_d;
   logic [DW-1:0] b_sh_q,       b_sh_d;
   logic [DW-1:0] a_q,          a_d;
   logic [DW-1:0] b_q,          b_d;
   logic          imem_we_q,    imem_we_d;
   logic [AW-1:0] imem_addr_q,  imem_addr_d;
   logic [IW-1:0] imem_wdata_q, imem_wdata_d;
   logic          in_ready_q,   in_ready_d;
   logic          cpu_run_q,    cpu_run_d;
   logic          busy_q,       busy_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    csum_q,       csum_d;
   logic          err_q,        err_d;
`endif

   logic xfer_s;
   logic last_word_s;

   assign xfer_s = in_valid & in_ready_q;
   // The word being completed is the final one when index+1 reaches N.
   assign last_word_s = ({24'd0, n_q} == (32'(word_idx_q) + 32'd1));

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      word_idx_d   = word_idx_q;
      byte_cnt_d   = byte_cnt_q;
      word_sr_d    = word_sr_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      a_d          = a_q;
      b_d          = b_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      in_ready_d   = 1'b0;
      cpu_run_d    = 1'b0;
      busy_d       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
      err_d        = 1'b0;
      if (xfer_s && (state_q != S_IDLE)) begin
         csum_d = xor_fold(csum_q, in_data);
      end else begin
         csum_d = csum_q;
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (xfer_s) begin
               n_d        = in_data;
               word_idx_d = {AW{1'b0}};
               byte_cnt_d = 4'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = in_data;
`endif
               if (in_data == 8'd0) begin
                  state_d = S_OPA;
               end else begin
                  state_d = S_INSTR;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_INSTR: begin
            if (xfer_s) begin
               word_sr_d = shift_word(word_sr_q, in_data);
               if (byte_cnt_q == IW_LAST) begin
                  // Word complete: strobe it out on the next cycle.
                  byte_cnt_d   = 4'd0;
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_idx_q;
                  imem_wdata_d = shift_word(word_sr_q, in_data);
                  word_idx_d   = word_idx_q + {{(AW-1){1'b0}}, 1'b1};
                  if (last_word_s) begin
                     state_d = S_OPA;
                  end else begin
                     state_d = S_INSTR;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
               end
            end else begin
               state_d = S_INSTR;
            end
         end
         S_OPA: begin
            if (xfer_s) begin
               a_sh_d = shift_opnd(a_sh_q, in_data);
               if (byte_cnt_q == DW_LAST) begin
                  byte_cnt_d = 4'd0;
                  state_d    = S_OPB;
               end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
               end
            end else begin
               state_d = S_OPA;
            end
         end
         S_OPB: begin
            if (xfer_s) begin
               b_sh_d = shift_opnd(b_sh_q, in_data);
               if (byte_cnt_q == DW_LAST) begin
                  byte_cnt_d = 4'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d    = S_CHK;
`else
                  // Operands become visible together on entry to RUN.
                  state_d    = S_RUN;
                  a_d        = a_sh_q;
                  b_d        = shift_opnd(b_sh_q, in_data);
`endif
               end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
               end
            end else begin
               state_d = S_OPB;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer_s) begin
               if (xor_fold(csum_q, in_data) == 8'd0) begin
                  state_d = S_RUN;
                  a_d     = a_sh_q;
                  b_d     = b_sh_q;
               end else begin
                  state_d = S_ERR;
               end
            end else begin
               state_d = S_CHK;
            end
         end
         S_ERR: begin
            if (restart) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ERR;
            end
         end
`endif
         S_RUN: begin
            if (restart) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered from the state being entered.
      case (state_d)
         S_IDLE: begin
            in_ready_d = 1'b1;
         end
         S_INSTR, S_OPA, S_OPB: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
         end
         S_RUN: begin
            cpu_run_d = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
         end
         S_ERR: begin
            err_d = 1'b1;
         end
`endif
         default: begin
            in_ready_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         n_q          <= 8'd0;
         word_idx_q   <= {AW{1'b0}};
         byte_cnt_q   <= 4'd0;
         word_sr_q    <= {IW{1'b0}};
         a_sh_q       <= {DW{1'b0}};
         b_sh_q       <= {DW{1'b0}};
         a_q          <= {DW{1'b0}};
         b_q          <= {DW{1'b0}};
         imem_we_q    <= 1'b0;
         imem_addr_q  <= {AW{1'b0}};
         imem_wdata_q <= {IW{1'b0}};
         in_ready_q   <= 1'b0;
         cpu_run_q    <= 1'b0;
         busy_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= 8'd0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         word_idx_q   <= word_idx_d;
         byte_cnt_q   <= byte_cnt_d;
         word_sr_q    <= word_sr_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         a_q          <= a_d;
         b_q          <= b_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         in_ready_q   <= in_ready_d;
         cpu_run_q    <= cpu_run_d;
         busy_q       <= busy_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
         err_q        <= err_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign a          = a_q;
   assign b          = b_q;
   assign cpu_run    = cpu_run_q;
   assign busy       = busy_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule
